// File: rtl/key_action_mapper_pkg.sv
// Shared constants for the keyboard action mapper: PS/2 key codes, the break marker,
// action indices, the default action code table and the repeat FSM state type.
package keyboardPkg;

  localparam logic [15:0] RELEASED  = 16'h00F0;

  localparam logic [15:0] KEY_A     = 16'h001C;
  localparam logic [15:0] KEY_D     = 16'h0023;
  localparam logic [15:0] KEY_SPACE = 16'h0029;
  localparam logic [15:0] KEY_W     = 16'h001D;
  localparam logic [15:0] KEY_S     = 16'h001B;
  localparam logic [15:0] KEY_ENTER = 16'h005A;

  localparam int ACT_LEFT  = 0;
  localparam int ACT_RIGHT = 1;
  localparam int ACT_JUMP  = 2;
  localparam int ACT_UP    = 3;
  localparam int ACT_DOWN  = 4;
  localparam int ACT_START = 5;

  localparam int NUM_DEFAULT_ACTIONS = 6;

  localparam logic [15:0] DEFAULT_ACTION_CODES [NUM_DEFAULT_ACTIONS] =
    '{KEY_A, KEY_D, KEY_SPACE, KEY_W, KEY_S, KEY_ENTER};

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } repeat_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_action_mapper_repeat_timer.sv
// Auto-repeat timer: tracks the lowest-index newly pressed action and emits
// timed repeat pulses for it until it is released, cleared or replaced.
module key_repeat_timer
  import keyboardPkg::*;
#(
  parameter int NUM_ACTIONS   = 6,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [NUM_ACTIONS-1:0] make_i,
  input  logic [NUM_ACTIONS-1:0] brk_i,
  output logic [NUM_ACTIONS-1:0] rep_o,
  output repeat_state_t          state_o
);

  localparam int CNT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam int ACT_W = (NUM_ACTIONS > 1) ? $clog2(NUM_ACTIONS) : 1;

  repeat_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACT_W-1:0] act_q, act_d;
  logic [ACT_W-1:0] low_idx;
  logic             rep_due;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_ACTIONS - 1; i >= 0; i--) begin
      if (make_i[i]) low_idx = ACT_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    rep_due = 1'b0;
    case (state_q)
      RPT_DELAY: begin
        if (cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
          rep_due = 1'b1;
          state_d = RPT_REPEAT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RPT_REPEAT: begin
        if (cnt_q == CNT_W'(REPEAT_PERIOD - 1)) begin
          rep_due = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase
    // Priority, lowest to highest: timing, release of the tracked key, new press, clear.
    if (state_q != RPT_IDLE && brk_i[act_q]) begin
      state_d = RPT_IDLE;
      cnt_d   = '0;
    end
    if (|make_i) begin
      state_d = RPT_DELAY;
      cnt_d   = '0;
      act_d   = low_idx;
    end
    if (clear) begin
      state_d = RPT_IDLE;
      cnt_d   = '0;
    end
  end

  // A due repeat pulse yields to any key event or clear in the same cycle.
  always_comb begin
    rep_o = '0;
    if (rep_due && !clear && !(|make_i) && !(|brk_i)) rep_o[act_q] = 1'b1;
  end

  assign state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RPT_IDLE;
      cnt_q   <= '0;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
    end
  end

endmodule

// File: rtl/key_action_mapper.sv
// Maps PS/2 make/break key events to held levels, press/release pulses and facing.
// Build with KEY_REPEAT_EN defined to add timed auto-repeat press pulses.
module key_action_mapper
  import keyboardPkg::*;
#(
  parameter int          NUM_ACTIONS                = 6,
  parameter logic [15:0] ACTION_CODES [NUM_ACTIONS] = keyboardPkg::DEFAULT_ACTION_CODES,
  parameter int          LEFT_IDX                   = 0,
  parameter int          RIGHT_IDX                  = 1,
  parameter int          REPEAT_DELAY               = 25_000_000,
  parameter int          REPEAT_PERIOD              = 5_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            key_code,
  input  logic                   key_valid,
  input  logic                   clear,
  output logic [NUM_ACTIONS-1:0] held,
  output logic [NUM_ACTIONS-1:0] pressed,
  output logic [NUM_ACTIONS-1:0] released,
  output logic                   facing,
  output logic                   any_held
);

  // key_valid is a one-cycle strobe with no backpressure: key_code is consumed
  // in exactly the cycle key_valid is high, unless clear is also high.
  logic [NUM_ACTIONS-1:0] hit;
  logic                   brk;
  logic                   ev;
  logic [NUM_ACTIONS-1:0] make_pulse, brk_pulse, rep_pulse;

  logic [NUM_ACTIONS-1:0] held_q, held_d;
  logic [NUM_ACTIONS-1:0] pressed_q, pressed_d;
  logic [NUM_ACTIONS-1:0] released_q, released_d;
  logic                   facing_q, facing_d;
  logic                   any_held_q, any_held_d;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_ACTIONS; i++) begin
      hit[i] = (key_code[15:0] == ACTION_CODES[i]);
    end
  end

  assign brk        = (key_code[31:16] == RELEASED);
  assign ev         = key_valid && !clear;
  assign make_pulse = (ev && !brk) ? (hit & ~held_q) : '0;
  assign brk_pulse  = (ev &&  brk) ? (hit &  held_q) : '0;

`ifdef KEY_REPEAT_EN
  repeat_state_t dbg_state_unused;

  key_repeat_timer #(
    .NUM_ACTIONS  (NUM_ACTIONS),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_repeat (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .make_i (make_pulse),
    .brk_i  (brk_pulse),
    .rep_o  (rep_pulse),
    .state_o(dbg_state_unused)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
  assign rep_pulse  = '0;
`endif

  always_comb begin
    held_d     = clear ? '0 : ((held_q | make_pulse) & ~brk_pulse);
    pressed_d  = make_pulse | rep_pulse;
    released_d = brk_pulse;
    any_held_d = |held_d;
    facing_d   = facing_q;
    if (make_pulse[LEFT_IDX])       facing_d = 1'b1;
    else if (make_pulse[RIGHT_IDX]) facing_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q     <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      facing_q   <= 1'b0;
      any_held_q <= 1'b0;
    end else begin
      held_q     <= held_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      facing_q   <= facing_d;
      any_held_q <= any_held_d;
    end
  end

  assign held     = held_q;
  assign pressed  = pressed_q;
  assign released = released_q;
  assign facing   = facing_q;
  assign any_held = any_held_q;

endmodule
